// File: rtl/hdlc_line_monitor.sv
// Multi-channel HDLC line monitor: flag/abort/frame-boundary detection per line,
// frame length checks after zero removal, event pulses and saturating counters.

module hdlc_line_chan #(
    parameter int CNT_WIDTH = 16,
    parameter int MIN_BYTES = 4,
    parameter int MAX_BYTES = 128,
    parameter int LEN_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_en,
    input  logic                 line_bit,
    input  logic                 cnt_clr,
    output logic                 flag_det,
    output logic                 abort_det,
    output logic                 frame_good,
    output logic                 frame_err,
    output logic                 in_frame,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic [CNT_WIDTH-1:0] abort_cnt
);
    typedef enum logic {HUNT = 1'b0, OPEN = 1'b1} state_t;

    localparam logic [LEN_WIDTH-1:0] DB_SAT    = '1;
    localparam logic [LEN_WIDTH-1:0] FLAG_HEAD = LEN_WIDTH'(7);
    localparam logic [LEN_WIDTH-1:0] MIN_LEN   = LEN_WIDTH'(MIN_BYTES * 8);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN   = LEN_WIDTH'(MAX_BYTES * 8);
    localparam logic [CNT_WIDTH-1:0] CNT_SAT   = '1;

    state_t               state, state_nxt;
    logic [7:0]           sr, sr_nxt;
    logic [2:0]           ones, ones_nxt;
    logic [LEN_WIDTH-1:0] db, db_nxt, len;
    logic                 flag_nxt, abort_nxt, good_nxt, err_nxt;

    // DB includes the first seven bits of the closing flag, hence the offset.
    assign len      = db - FLAG_HEAD;
    assign in_frame = (state == OPEN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            sr         <= 8'hFF;
            ones       <= '0;
            db         <= '0;
            flag_det   <= 1'b0;
            abort_det  <= 1'b0;
            frame_good <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            sr         <= sr_nxt;
            ones       <= ones_nxt;
            db         <= db_nxt;
            flag_det   <= flag_nxt;
            abort_det  <= abort_nxt;
            frame_good <= good_nxt;
            frame_err  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        ones_nxt  = ones;
        db_nxt    = db;
        flag_nxt  = 1'b0;
        abort_nxt = 1'b0;
        good_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (bit_en) begin
            sr_nxt = {sr[6:0], line_bit};
            if (!line_bit)
                ones_nxt = '0;
            else if (ones != 3'd7)
                ones_nxt = ones + 3'd1;

            if (state == HUNT) begin
                db_nxt = '0;
                if (sr_nxt == 8'h7E) begin
                    flag_nxt  = 1'b1;
                    state_nxt = OPEN;
                end
            end else if (sr_nxt == 8'h7E) begin
                flag_nxt = 1'b1;
                db_nxt   = '0;
                if (db > FLAG_HEAD) begin
                    if (db != DB_SAT && len[2:0] == 3'd0 && len >= MIN_LEN && len <= MAX_LEN)
                        good_nxt = 1'b1;
                    else
                        err_nxt = 1'b1;
                end
            end else if (line_bit && ones == 3'd6) begin
                // Seventh one: abort inside a frame, plain idle right after a flag.
                abort_nxt = (db > FLAG_HEAD);
                state_nxt = HUNT;
                db_nxt    = '0;
            end else if (!(!line_bit && ones == 3'd5)) begin
                if (db != DB_SAT)
                    db_nxt = db + LEN_WIDTH'(1);
            end
        end
    end

    // Clear has priority over a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
            abort_cnt <= '0;
        end else begin
            if (good_nxt && frame_cnt != CNT_SAT)
                frame_cnt <= frame_cnt + CNT_WIDTH'(1);
            if (err_nxt && err_cnt != CNT_SAT)
                err_cnt <= err_cnt + CNT_WIDTH'(1);
            if (abort_nxt && abort_cnt != CNT_SAT)
                abort_cnt <= abort_cnt + CNT_WIDTH'(1);
        end
    end
endmodule

module hdlc_line_monitor #(
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 16,
    parameter int MIN_BYTES = 4,
    parameter int MAX_BYTES = 128,
    parameter int LEN_WIDTH = $clog2(MAX_BYTES * 8 + 16) + 1
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [CHANNELS-1:0]           BitEn,
    input  logic [CHANNELS-1:0]           Line,
    input  logic                          CntClr,
    output logic [CHANNELS-1:0]           FlagDet,
    output logic [CHANNELS-1:0]           AbortDet,
    output logic [CHANNELS-1:0]           FrameGood,
    output logic [CHANNELS-1:0]           FrameErr,
    output logic [CHANNELS-1:0]           InFrame,
    output logic [CHANNELS*CNT_WIDTH-1:0] FrameCnt,
    output logic [CHANNELS*CNT_WIDTH-1:0] ErrCnt,
    output logic [CHANNELS*CNT_WIDTH-1:0] AbortCnt
);
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        hdlc_line_chan #(
            .CNT_WIDTH(CNT_WIDTH),
            .MIN_BYTES(MIN_BYTES),
            .MAX_BYTES(MAX_BYTES),
            .LEN_WIDTH(LEN_WIDTH)
        ) u_chan (
            .clk       (Clk),
            .rst       (Rst),
            .bit_en    (BitEn[c]),
            .line_bit  (Line[c]),
            .cnt_clr   (CntClr),
            .flag_det  (FlagDet[c]),
            .abort_det (AbortDet[c]),
            .frame_good(FrameGood[c]),
            .frame_err (FrameErr[c]),
            .in_frame  (InFrame[c]),
            .frame_cnt (FrameCnt[c*CNT_WIDTH +: CNT_WIDTH]),
            .err_cnt   (ErrCnt[c*CNT_WIDTH +: CNT_WIDTH]),
            .abort_cnt (AbortCnt[c*CNT_WIDTH +: CNT_WIDTH])
        );
    end
endmodule

// File: tb/tb_hdlc_line_monitor.sv
// Randomized bench for hdlc_line_monitor: frames are built at item level (flag, bytes,
// abort, idle) and the expected per-bit events come from frame-level rules.

module tb_hdlc_line_monitor;
    localparam int CH = 4, CW = 16, CW2 = 2, MINB = 4, MAXB = 128;

    logic Clk = 1'b0, Rst = 1'b1, CntClr = 1'b0;
    logic [CH-1:0] BitEn = '0, Line = '1;
    logic [CH-1:0] FlagDet, AbortDet, FrameGood, FrameErr, InFrame;
    logic [CH*CW-1:0] FrameCnt, ErrCnt, AbortCnt;
    logic [CH-1:0] f2, a2, g2, e2, i2;
    logic [CH*CW2-1:0] FrameCnt2, ErrCnt2, AbortCnt2;

    always #5 Clk = ~Clk;

    hdlc_line_monitor #(.CHANNELS(CH), .CNT_WIDTH(CW), .MIN_BYTES(MINB), .MAX_BYTES(MAXB)) dut (
        .Clk(Clk), .Rst(Rst), .BitEn(BitEn), .Line(Line), .CntClr(CntClr),
        .FlagDet(FlagDet), .AbortDet(AbortDet), .FrameGood(FrameGood), .FrameErr(FrameErr),
        .InFrame(InFrame), .FrameCnt(FrameCnt), .ErrCnt(ErrCnt), .AbortCnt(AbortCnt));

    hdlc_line_monitor #(.CHANNELS(CH), .CNT_WIDTH(CW2), .MIN_BYTES(MINB), .MAX_BYTES(MAXB)) dut2 (
        .Clk(Clk), .Rst(Rst), .BitEn(BitEn), .Line(Line), .CntClr(CntClr),
        .FlagDet(f2), .AbortDet(a2), .FrameGood(g2), .FrameErr(e2),
        .InFrame(i2), .FrameCnt(FrameCnt2), .ErrCnt(ErrCnt2), .AbortCnt(AbortCnt2));

    // Per channel: line bits to send, expected {in_frame, flag, abort, good, err}
    // after each bit, and what was observed.
    bit         q_bit[CH][$];
    logic [4:0] q_exp[CH][$];
    logic [4:0] q_obs[CH][$];
    bit         m_open[CH];
    int         m_data[CH], m_ones[CH], cnt_good[CH], cnt_err[CH], cnt_abort[CH];
    int         n_cmp = 0, n_bad = 0, stray = 0;
    bit         timeout = 0;

    task automatic model_clear();
        for (int c = 0; c < CH; c++) begin
            m_open[c] = 0; m_data[c] = 0; m_ones[c] = 0;
            cnt_good[c] = 0; cnt_err[c] = 0; cnt_abort[c] = 0;
        end
    endtask

    task automatic push(input int c, input bit b, input logic [3:0] ev);
        q_bit[c].push_back(b);
        q_exp[c].push_back({m_open[c], ev});
    endtask

    // Closing flag: frame verdict is made from the count of data bits sent since the last flag.
    task automatic m_flag(input int c);
        logic [3:0] ev;
        push(c, 0, 4'b0);
        repeat (6) push(c, 1, 4'b0);
        ev = 4'b1000;
        if (m_open[c] && m_data[c] > 0) begin
            if (m_data[c] % 8 == 0 && m_data[c] >= MINB*8 && m_data[c] <= MAXB*8) begin
                ev[1] = 1; cnt_good[c]++;
            end else begin
                ev[0] = 1; cnt_err[c]++;
            end
        end
        m_open[c] = 1; m_data[c] = 0; m_ones[c] = 0;
        push(c, 0, ev);
    endtask

    // Flag sharing its leading zero with the previous flag (only right after a flag).
    task automatic m_flag_shared(input int c);
        repeat (6) push(c, 1, 4'b0);
        push(c, 0, 4'b1000);
    endtask

    task automatic m_dbit(input int c, input bit b);
        push(c, b, 4'b0);
        if (m_open[c]) m_data[c]++;
        if (b) begin
            m_ones[c]++;
            if (m_ones[c] == 5) begin push(c, 0, 4'b0); m_ones[c] = 0; end
        end else m_ones[c] = 0;
    endtask

    task automatic m_byte(input int c, input logic [7:0] v);
        for (int i = 0; i < 8; i++) m_dbit(c, v[i]);
    endtask

    task automatic m_rand_bits(input int c, input int n);
        for (int i = 0; i < n; i++) m_dbit(c, bit'($urandom % 2));
    endtask

    task automatic m_abort(input int c);
        bit ab;
        ab = m_open[c] && m_data[c] > 0;
        push(c, 0, 4'b0);
        repeat (6) push(c, 1, 4'b0);
        m_open[c] = 0; m_data[c] = 0; m_ones[c] = 0;
        push(c, 1, ab ? 4'b0100 : 4'b0);
        if (ab) cnt_abort[c]++;
    endtask

    task automatic m_idle(input int c, input int k);
        for (int i = 0; i < k; i++) begin
            if (i == 6) m_open[c] = 0;
            push(c, 1, 4'b0);
        end
    endtask

    task automatic build_random(input int c);
        m_flag(c);
        repeat (5) begin
            case ($urandom % 4)
                0: begin
                    repeat ($urandom_range(MINB, MINB + 5)) m_byte(c, 8'($urandom));
                    m_flag(c);
                end
                1: begin m_rand_bits(c, $urandom_range(1, 60)); m_flag(c); end
                2: begin m_rand_bits(c, $urandom_range(1, 30)); m_abort(c); m_flag(c); end
                default: m_flag_shared(c);
            endcase
        end
    endtask

    // Drives queued bits; period>0 strobes channel c when (cycle+c)%period==0, period 0 strobes randomly.
    task automatic run(input int period, input int clr_idx);
        int cyc;
        int sent[CH];
        bit smp[CH];
        bit any;
        logic [4:0] code;
        cyc = 0; stray = 0; timeout = 0;
        for (int c = 0; c < CH; c++) sent[c] = 0;
        forever begin
            any = 0;
            for (int c = 0; c < CH; c++) if (q_bit[c].size() != 0) any = 1;
            if (!any) break;
            if (cyc > 30000) begin timeout = 1; break; end
            @(negedge Clk);
            CntClr = 1'b0;
            for (int c = 0; c < CH; c++) begin
                smp[c] = q_bit[c].size() != 0 &&
                         (period == 0 ? ($urandom % 2 == 1) : ((cyc + c) % period == 0));
                BitEn[c] = smp[c];
                Line[c]  = smp[c] ? q_bit[c][0] : 1'b1;
                if (smp[c] && c == 0 && sent[0] == clr_idx) CntClr = 1'b1;
            end
            @(posedge Clk); #1;
            for (int c = 0; c < CH; c++) begin
                code = {InFrame[c], FlagDet[c], AbortDet[c], FrameGood[c], FrameErr[c]};
                if (smp[c]) begin
                    q_obs[c].push_back(code);
                    void'(q_bit[c].pop_front());
                    sent[c]++;
                end else if (code[3:0] != 4'b0) stray++;
            end
            cyc++;
        end
        @(negedge Clk);
        BitEn = '0; Line = '1; CntClr = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            BitEn = CH'($urandom); Line = CH'($urandom);
            @(posedge Clk); #1;
            n_cmp++;
            if ({FlagDet, AbortDet, FrameGood, FrameErr, InFrame} !== '0 ||
                FrameCnt !== '0 || ErrCnt !== '0 || AbortCnt !== '0 || FrameCnt2 !== '0) begin
                n_bad++;
                $display("FAIL reset outputs: got pulses=%h in=%b cnt=%h/%h/%h required all 0",
                         {FlagDet, AbortDet, FrameGood, FrameErr}, InFrame, FrameCnt, ErrCnt, AbortCnt);
            end
        end
        @(negedge Clk);
        Rst = 1'b0; BitEn = '0; Line = '1;
        model_clear();
    endtask

    task automatic test_good_frame();
        m_idle(0, 10); m_flag(0);
        m_byte(0, 8'h00); m_byte(0, 8'h11); m_byte(0, 8'h22); m_byte(0, 8'h33);
        m_flag(0);
        m_flag(1); m_byte(1, 8'hFF); m_byte(1, 8'h00); m_byte(1, 8'h11); m_byte(1, 8'h22); m_flag(1);
        m_flag(2); repeat (5) m_byte(2, 8'hFF); m_flag(2);
        m_flag(3); repeat (6) m_byte(3, 8'($urandom)); m_flag(3);
        run(1, -1);
        n_cmp++;
        if (timeout || stray != 0) begin n_bad++; $display("FAIL good_frame run: timeout=%0d stray=%0d required 0/0", timeout, stray); end
        for (int c = 0; c < CH; c++) begin
            n_cmp++;
            if (q_obs[c].size() != q_exp[c].size()) begin
                n_bad++; $display("FAIL good_frame ch%0d samples: got %0d required %0d", c, q_obs[c].size(), q_exp[c].size());
            end else for (int i = 0; i < q_exp[c].size(); i++) begin
                n_cmp++;
                if (q_obs[c][i] !== q_exp[c][i]) begin
                    n_bad++; $display("FAIL good_frame ch%0d bit %0d {in,flag,abort,good,err}: got %b required %b", c, i, q_obs[c][i], q_exp[c][i]);
                end
            end
            n_cmp++;
            if ({FrameCnt[c*CW +: CW], ErrCnt[c*CW +: CW], AbortCnt[c*CW +: CW]} !== {CW'(cnt_good[c]), CW'(cnt_err[c]), CW'(cnt_abort[c])}) begin
                n_bad++; $display("FAIL good_frame ch%0d counters good/err/abort: got %0d/%0d/%0d required %0d/%0d/%0d", c,
                    FrameCnt[c*CW +: CW], ErrCnt[c*CW +: CW], AbortCnt[c*CW +: CW], cnt_good[c], cnt_err[c], cnt_abort[c]);
            end
            q_exp[c].delete(); q_obs[c].delete();
        end
    endtask

    task automatic test_bad_frames();
        m_flag(0); m_rand_bits(0, 35); m_flag(0);
        repeat (3) m_byte(0, 8'($urandom)); m_flag(0);
        m_flag(1); repeat (MAXB) m_byte(1, 8'($urandom)); m_flag(1);
        repeat (MAXB + 1) m_byte(1, 8'($urandom)); m_flag(1);
        m_flag(2); m_rand_bits(2, 4100); m_flag(2);
        m_flag(3); m_flag_shared(3); m_flag(3); m_rand_bits(3, 7); m_flag(3);
        m_rand_bits(3, 40); m_flag(3);
        run(1, -1);
        n_cmp++;
        if (timeout || stray != 0) begin n_bad++; $display("FAIL bad_frames run: timeout=%0d stray=%0d required 0/0", timeout, stray); end
        for (int c = 0; c < CH; c++) begin
            n_cmp++;
            if (q_obs[c].size() != q_exp[c].size()) begin
                n_bad++; $display("FAIL bad_frames ch%0d samples: got %0d required %0d", c, q_obs[c].size(), q_exp[c].size());
            end else for (int i = 0; i < q_exp[c].size(); i++) begin
                n_cmp++;
                if (q_obs[c][i] !== q_exp[c][i]) begin
                    n_bad++; $display("FAIL bad_frames ch%0d bit %0d {in,flag,abort,good,err}: got %b required %b", c, i, q_obs[c][i], q_exp[c][i]);
                end
            end
            n_cmp++;
            if ({FrameCnt[c*CW +: CW], ErrCnt[c*CW +: CW], AbortCnt[c*CW +: CW]} !== {CW'(cnt_good[c]), CW'(cnt_err[c]), CW'(cnt_abort[c])}) begin
                n_bad++; $display("FAIL bad_frames ch%0d counters good/err/abort: got %0d/%0d/%0d required %0d/%0d/%0d", c,
                    FrameCnt[c*CW +: CW], ErrCnt[c*CW +: CW], AbortCnt[c*CW +: CW], cnt_good[c], cnt_err[c], cnt_abort[c]);
            end
            q_exp[c].delete(); q_obs[c].delete();
        end
    endtask

    task automatic test_abort();
        m_flag(0); m_rand_bits(0, 12); m_abort(0); m_flag(0); m_idle(0, 10);
        m_flag(1); m_abort(1); m_flag(1); m_rand_bits(1, 40); m_abort(1);
        m_flag(1); repeat (4) m_byte(1, 8'($urandom)); m_flag(1);
        m_flag(2); m_idle(2, 9); m_flag(2); m_rand_bits(2, 33); m_abort(2);
        run(2, -1);
        n_cmp++;
        if (timeout || stray != 0) begin n_bad++; $display("FAIL abort run: timeout=%0d stray=%0d required 0/0", timeout, stray); end
        for (int c = 0; c < CH; c++) begin
            n_cmp++;
            if (q_obs[c].size() != q_exp[c].size()) begin
                n_bad++; $display("FAIL abort ch%0d samples: got %0d required %0d", c, q_obs[c].size(), q_exp[c].size());
            end else for (int i = 0; i < q_exp[c].size(); i++) begin
                n_cmp++;
                if (q_obs[c][i] !== q_exp[c][i]) begin
                    n_bad++; $display("FAIL abort ch%0d bit %0d {in,flag,abort,good,err}: got %b required %b", c, i, q_obs[c][i], q_exp[c][i]);
                end
            end
            n_cmp++;
            if ({FrameCnt[c*CW +: CW], ErrCnt[c*CW +: CW], AbortCnt[c*CW +: CW]} !== {CW'(cnt_good[c]), CW'(cnt_err[c]), CW'(cnt_abort[c])}) begin
                n_bad++; $display("FAIL abort ch%0d counters good/err/abort: got %0d/%0d/%0d required %0d/%0d/%0d", c,
                    FrameCnt[c*CW +: CW], ErrCnt[c*CW +: CW], AbortCnt[c*CW +: CW], cnt_good[c], cnt_err[c], cnt_abort[c]);
            end
            q_exp[c].delete(); q_obs[c].delete();
        end
    endtask

    task automatic test_multichannel(input int period);
        for (int c = 0; c < CH; c++) build_random(c);
        run(period, -1);
        n_cmp++;
        if (timeout || stray != 0) begin n_bad++; $display("FAIL multichannel p%0d run: timeout=%0d stray=%0d required 0/0", period, timeout, stray); end
        for (int c = 0; c < CH; c++) begin
            n_cmp++;
            if (q_obs[c].size() != q_exp[c].size()) begin
                n_bad++; $display("FAIL multichannel p%0d ch%0d samples: got %0d required %0d", period, c, q_obs[c].size(), q_exp[c].size());
            end else for (int i = 0; i < q_exp[c].size(); i++) begin
                n_cmp++;
                if (q_obs[c][i] !== q_exp[c][i]) begin
                    n_bad++; $display("FAIL multichannel p%0d ch%0d bit %0d {in,flag,abort,good,err}: got %b required %b", period, c, i, q_obs[c][i], q_exp[c][i]);
                end
            end
            n_cmp++;
            if ({FrameCnt[c*CW +: CW], ErrCnt[c*CW +: CW], AbortCnt[c*CW +: CW]} !== {CW'(cnt_good[c]), CW'(cnt_err[c]), CW'(cnt_abort[c])}) begin
                n_bad++; $display("FAIL multichannel p%0d ch%0d counters good/err/abort: got %0d/%0d/%0d required %0d/%0d/%0d", period, c,
                    FrameCnt[c*CW +: CW], ErrCnt[c*CW +: CW], AbortCnt[c*CW +: CW], cnt_good[c], cnt_err[c], cnt_abort[c]);
            end
            q_exp[c].delete(); q_obs[c].delete();
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < CH; c++) begin
            m_flag(c);
            repeat (4) begin
                repeat ($urandom_range(MINB, MINB + 3)) m_byte(c, 8'($urandom));
                m_flag(c);
            end
        end
        run(1, -1);
        n_cmp++;
        if (timeout || stray != 0) begin n_bad++; $display("FAIL back_to_back run: timeout=%0d stray=%0d required 0/0", timeout, stray); end
        for (int c = 0; c < CH; c++) begin
            n_cmp++;
            if (q_obs[c].size() != q_exp[c].size()) begin
                n_bad++; $display("FAIL back_to_back ch%0d samples: got %0d required %0d", c, q_obs[c].size(), q_exp[c].size());
            end else for (int i = 0; i < q_exp[c].size(); i++) begin
                n_cmp++;
                if (q_obs[c][i] !== q_exp[c][i]) begin
                    n_bad++; $display("FAIL back_to_back ch%0d bit %0d {in,flag,abort,good,err}: got %b required %b", c, i, q_obs[c][i], q_exp[c][i]);
                end
            end
            n_cmp++;
            if (FrameCnt[c*CW +: CW] !== CW'(cnt_good[c])) begin
                n_bad++; $display("FAIL back_to_back ch%0d FrameCnt: got %0d required %0d", c, FrameCnt[c*CW +: CW], cnt_good[c]);
            end
            q_exp[c].delete(); q_obs[c].delete();
        end
    endtask

    task automatic test_saturation();
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        model_clear();
        m_flag(0);
        repeat (5) begin
            repeat (4) m_byte(0, 8'($urandom));
            m_flag(0);
        end
        run(1, -1);
        n_cmp++;
        if (FrameCnt2[0 +: CW2] !== 2'd3 || FrameCnt[0 +: CW] !== CW'(cnt_good[0]) || timeout) begin
            n_bad++; $display("FAIL saturation FrameCnt narrow/wide: got %0d/%0d required 3/%0d", FrameCnt2[0 +: CW2], FrameCnt[0 +: CW], cnt_good[0]);
        end
        for (int i = 0; i < q_exp[0].size(); i++) begin
            n_cmp++;
            if (i >= q_obs[0].size() || q_obs[0][i] !== q_exp[0][i]) begin
                n_bad++; $display("FAIL saturation ch0 bit %0d events: got %b required %b", i, (i < q_obs[0].size()) ? q_obs[0][i] : 5'bx, q_exp[0][i]);
            end
        end
        q_exp[0].delete(); q_obs[0].delete();
        // Clear coinciding with the closing flag's last bit: pulse still fires, counter reads 0.
        repeat (4) m_byte(0, 8'($urandom));
        m_flag(0);
        run(1, q_bit[0].size() - 1);
        n_cmp++;
        if (FrameGood[0] !== 1'b1 && q_obs[0].size() > 0 && q_obs[0][q_obs[0].size()-1][1] !== 1'b1) begin
            n_bad++; $display("FAIL clear_vs_incr FrameGood: got %b required 1", q_obs[0][q_obs[0].size()-1][1]);
        end
        n_cmp++;
        if (FrameCnt !== '0 || ErrCnt !== '0 || AbortCnt !== '0 || FrameCnt2 !== '0) begin
            n_bad++; $display("FAIL clear_vs_incr counters: got %h/%h/%h narrow %h required all 0", FrameCnt, ErrCnt, AbortCnt, FrameCnt2);
        end
        model_clear();
        for (int c = 0; c < CH; c++) m_open[c] = (c == 0);
        q_exp[0].delete(); q_obs[0].delete();
    endtask

    task automatic test_reset_midframe();
        m_flag(0); repeat (4) m_byte(0, 8'($urandom)); m_flag(0); m_rand_bits(0, 20);
        run(1, -1);
        n_cmp++;
        if (FrameCnt[0 +: CW] !== CW'(cnt_good[0]) || InFrame[0] !== 1'b1) begin
            n_bad++; $display("FAIL midframe pre-reset: got cnt=%0d in=%b required %0d/1", FrameCnt[0 +: CW], InFrame[0], cnt_good[0]);
        end
        q_exp[0].delete(); q_obs[0].delete();
        @(negedge Clk);
        Rst = 1'b1; BitEn = '1; Line = CH'($urandom);
        @(posedge Clk); #1;
        n_cmp++;
        if ({FlagDet, AbortDet, FrameGood, FrameErr, InFrame} !== '0 || FrameCnt !== '0 || ErrCnt !== '0 || AbortCnt !== '0) begin
            n_bad++; $display("FAIL midframe reset: got pulses=%h in=%b cnt=%h required all 0",
                              {FlagDet, AbortDet, FrameGood, FrameErr}, InFrame, FrameCnt);
        end
        @(negedge Clk);
        Rst = 1'b0; BitEn = '0; Line = '1;
        model_clear();
        m_rand_bits(0, 20); m_flag(0); repeat (4) m_byte(0, 8'($urandom)); m_flag(0);
        run(1, -1);
        n_cmp++;
        if (timeout || stray != 0) begin n_bad++; $display("FAIL midframe run: timeout=%0d stray=%0d required 0/0", timeout, stray); end
        for (int i = 0; i < q_exp[0].size(); i++) begin
            n_cmp++;
            if (i >= q_obs[0].size() || q_obs[0][i] !== q_exp[0][i]) begin
                n_bad++; $display("FAIL midframe ch0 bit %0d events: got %b required %b", i, (i < q_obs[0].size()) ? q_obs[0][i] : 5'bx, q_exp[0][i]);
            end
        end
        n_cmp++;
        if (FrameCnt[0 +: CW] !== 16'd1 || ErrCnt[0 +: CW] !== 16'd0) begin
            n_bad++; $display("FAIL midframe counters good/err: got %0d/%0d required 1/0", FrameCnt[0 +: CW], ErrCnt[0 +: CW]);
        end
        q_exp[0].delete(); q_obs[0].delete();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_good_frame();
        test_bad_frames();
        test_abort();
        test_multichannel(3);
        test_multichannel(0);
        test_back_to_back();
        test_saturation();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hdlc_line_monitor.md
# hdlc_line_monitor

Synthesizable, multi-channel HDLC bitstream monitor. It watches one or more serial HDLC lines (Tx or Rx side) and detects flags, aborts and frame boundaries on each. Each closed frame is checked for byte alignment and length after zero-removal. Per-channel event pulses and saturating statistics counters are kept, so line checks can run in hardware and on the bench.

## Interface
- CHANNELS, 4: number of independent monitored lines.
- CNT_WIDTH, 16: width of each statistics counter.
- MIN_BYTES, 4: minimum legal frame length in bytes, after zero removal.
- MAX_BYTES, 128: maximum legal frame length in bytes.
- LEN_WIDTH, $clog2(MAX_BYTES*8+16)+1: width of the internal per-channel bit counter.
- Clk  in  1  system clock; one clock for the whole block.
- Rst  in  1  synchronous, active-high reset.
- BitEn  in  CHANNELS  per-channel bit strobe; the line bit is sampled at a rising Clk edge only while its strobe is 1.
- Line  in  CHANNELS  serial line bits, one per channel.
- CntClr  in  1  synchronous clear of all counters, all channels.
- FlagDet  out  CHANNELS  one-cycle pulse: flag 0111_1110 completed.
- AbortDet  out  CHANNELS  one-cycle pulse: abort seen inside a frame.
- FrameGood  out  CHANNELS  one-cycle pulse: legal frame closed.
- FrameErr  out  CHANNELS  one-cycle pulse: illegal frame closed.
- InFrame  out  CHANNELS  level: channel is in OPEN state.
- FrameCnt  out  CHANNELS*CNT_WIDTH  good-frame counters, channel c at [c*CNT_WIDTH +: CNT_WIDTH].
- ErrCnt  out  CHANNELS*CNT_WIDTH  error-frame counters, same packing.
- AbortCnt  out  CHANNELS*CNT_WIDTH  abort counters, same packing.

## Operation
Channels are fully independent; each channel has the logic below.
- Per-channel registers:
  - Shift register SR[7:0] holding the last 8 sampled bits, oldest first.
  - Ones run counter ONES, 0..7, saturating. Cleared on each 0.
  - Data bit counter DB, LEN_WIDTH bits, saturating.
  - State, HUNT or OPEN.
- Flag: the sampled bit completes 0111_1110 in time order. Shared-zero flags are detected naturally.
- Stuffed zero: a sampled 0 with ONES == 5. It is not counted in DB.
- In OPEN, every other sampled bit increments DB. The bit that completes a flag is not counted.
- HUNT:
  - Ones and stray zeros are ignored; DB is held at 0.
  - A flag pulses FlagDet, clears DB and moves to OPEN.
- OPEN, on a flag:
  - FlagDet pulses and L = DB − 7 is computed.
  - If DB ≤ 7, the flag is interframe fill or shared-zero fill. No frame event.
  - Else, if L mod 8 == 0 and MIN_BYTES*8 ≤ L ≤ MAX_BYTES*8, FrameGood pulses.
  - Otherwise FrameErr pulses, including when DB is saturated.
  - DB clears; the channel stays OPEN.
- OPEN, on the seventh consecutive 1 (ONES reaches 7):
  - If DB > 7, AbortDet pulses.
  - If DB ≤ 7, this is idle after a flag; no pulse.
  - Either way, go to HUNT and clear DB.
- Counters:
  - FrameCnt, ErrCnt and AbortCnt increment on the same edge that raises the matching pulse.
  - They saturate at 2^CNT_WIDTH−1.
  - CntClr wins over a simultaneous increment; the counter reads 0 in the next cycle.

## Timing
- Reset values: state HUNT, SR=8'hFF, ONES=0, DB=0. All pulses, InFrame and all counters are 0.
- Rst asserted mid-frame: state is reset at that edge. The partial frame is discarded with no pulse and no count.
- Latency: pulses are registered. A pulse is high for exactly the one cycle after the edge that sampled the completing bit.
- Counter values reflect the event in that same cycle.
- InFrame follows the state change at the same edge.
- BitEn[c]=0: channel c holds all state. Its pulses are 0 in the following cycle.
- BitEn may toggle every cycle; back-to-back sampled bits are supported at full rate.
- Simultaneous events:
  - Flag and frame-close on one bit: FlagDet and FrameGood or FrameErr pulse together.
  - Abort and flag cannot coincide.
- Saturation:
  - DB saturates at all-ones, forcing FrameErr at the next flag.
  - Counters saturate without wrap.

## Test plan
- Idle ones, then flag, 4 bytes 0x00 0x11 0x22 0x33, then flag, channel 0 -> FlagDet twice; FrameGood one cycle after the last flag bit; FrameCnt[0]=1; ErrCnt[0]=0.
- Data byte 0xFF with stuffed zero (line 11111 0 111), frame of 4 bytes -> FrameGood; the stuffed bit is not counted, so L=32.
- Flag, 35 data bits, flag -> FrameErr; ErrCnt=1. Also a 3-byte frame -> FrameErr.
- Flag, 12 data bits, 0 then seven 1s -> AbortDet on the seventh 1; InFrame drops; AbortCnt=1. Flag followed directly by idle ones -> no AbortDet.
- All 4 channels driven with different frames and BitEn strobing every third cycle -> per-channel counters independent and correct. A frame with BitEn low mid-frame is still accepted.
- CNT_WIDTH=2 with 5 good frames -> FrameCnt saturates at 3. CntClr in the same cycle as an increment -> 0. Rst mid-frame -> no pulses, all counters 0.
